// File: rtl/dso100fb_fetch_sched.sv
// Framebuffer fetch scheduler: round-robin burst requests for main and overlay planes.
// Overlay requester is present only when DSO100FB_OVERLAY_FETCH_EN is defined.
module dso100fb_fetch_sched #(
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              FRAME,
  input  logic [ADDR_W-1:0] FB_BASE,
  input  logic [ADDR_W-1:0] OV_BASE,
  input  logic [23:0]       FB_WORDS,
  input  logic [23:0]       OV_WORDS,
  input  logic              VID_WANT,
  input  logic              OV_WANT,
  output logic              MEM_REQ,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [7:0]        MEM_LEN,
  output logic              MEM_ID,
  input  logic              MEM_ACK,
  input  logic              MEM_DONE,
  output logic              BUSY,
  output logic              FRAME_LATE
);

  localparam int unsigned CNT_W  = 24;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned BEAT_W = 9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_REQ  = 2'd2,
    S_WAIT = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   fb_ptr_q, fb_ptr_d;
  logic [ADDR_W-1:0]   ov_ptr_q, ov_ptr_d;
  logic [CNT_W-1:0]    fb_rem_q, fb_rem_d;
  logic [CNT_W-1:0]    ov_rem_q, ov_rem_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LEN_W-1:0]    mem_len_q, mem_len_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_id_q, mem_id_d;
  logic                busy_q, busy_d;
  logic                frame_late_q, frame_late_d;
  logic                last_ov_q, last_ov_d;
  logic                reload_q, reload_d;
  logic                do_reload;

  // Overlay inputs are masked off when the overlay requester is not built.
  logic [ADDR_W-1:0]   ov_base_c;
  logic [CNT_W-1:0]    ov_words_c;
  logic                ov_want_c;

`ifdef DSO100FB_OVERLAY_FETCH_EN
  assign ov_base_c  = OV_BASE;
  assign ov_words_c = OV_WORDS;
  assign ov_want_c  = OV_WANT;
  assign MEM_ID     = mem_id_q;
`else
  logic unused_ov;
  assign unused_ov  = ^{OV_BASE, OV_WORDS, OV_WANT, mem_id_q};
  assign ov_base_c  = '0;
  assign ov_words_c = '0;
  assign ov_want_c  = 1'b0;
  assign MEM_ID     = 1'b0;
`endif

  logic                frame_c;
  logic                fb_el_c, ov_el_c, pick_ov_c;
  logic [CNT_W-1:0]    sel_rem_c;
  logic [BEAT_W-1:0]   beats_c, ack_beats_c;
  logic [ADDR_W-1:0]   step_c;

  assign frame_c   = FRAME && EN;
  assign fb_el_c   = VID_WANT && (fb_rem_q != '0);
  assign ov_el_c   = ov_want_c && (ov_rem_q != '0);
  // Overlay wins only if main is not eligible or main took the previous grant.
  assign pick_ov_c = ov_el_c && (!fb_el_c || !last_ov_q);
  assign sel_rem_c = pick_ov_c ? ov_rem_q : fb_rem_q;
  assign beats_c   = (sel_rem_c < CNT_W'(BURST_LEN)) ? BEAT_W'(sel_rem_c)
                                                     : BEAT_W'(BURST_LEN);
  assign ack_beats_c = BEAT_W'(mem_len_q) + BEAT_W'(1);
  assign step_c      = ADDR_W'({ack_beats_c, 2'b00});

  always_comb begin
    state_d      = state_q;
    fb_ptr_d     = fb_ptr_q;
    ov_ptr_d     = ov_ptr_q;
    fb_rem_d     = fb_rem_q;
    ov_rem_d     = ov_rem_q;
    mem_addr_d   = mem_addr_q;
    mem_len_d    = mem_len_q;
    mem_req_d    = mem_req_q;
    mem_id_d     = mem_id_q;
    last_ov_d    = last_ov_q;
    reload_d     = reload_q;
    frame_late_d = 1'b0;
    do_reload    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_c) begin
          do_reload = 1'b1;
          state_d   = S_ARB;
        end
      end

      S_ARB: begin
        frame_late_d = frame_c;
        if (!EN) begin
          state_d = S_IDLE;
        end else if (frame_c) begin
          do_reload = 1'b1;
        end else if ((fb_rem_q == '0) && (ov_rem_q == '0)) begin
          state_d = S_IDLE;
        end else if (fb_el_c || ov_el_c) begin
          state_d    = S_REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = pick_ov_c ? ov_ptr_q : fb_ptr_q;
          mem_len_d  = LEN_W'(beats_c - BEAT_W'(1));
          mem_id_d   = pick_ov_c;
          last_ov_d  = pick_ov_c;
        end
      end

      S_REQ: begin
        if (frame_c) begin
          frame_late_d = 1'b1;
          reload_d     = 1'b1;
        end
        if (MEM_ACK) begin
          mem_req_d = 1'b0;
          state_d   = S_WAIT;
          if (mem_id_q) begin
            ov_ptr_d = ov_ptr_q + step_c;
            ov_rem_d = ov_rem_q - CNT_W'(ack_beats_c);
          end else begin
            fb_ptr_d = fb_ptr_q + step_c;
            fb_rem_d = fb_rem_q - CNT_W'(ack_beats_c);
          end
        end
      end

      S_WAIT: begin
        frame_late_d = frame_c;
        if (MEM_DONE) begin
          if (!EN) begin
            state_d  = S_IDLE;
            reload_d = 1'b0;
          end else begin
            state_d   = S_ARB;
            do_reload = reload_q || frame_c;
          end
        end else if (frame_c) begin
          reload_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Frame restart: fresh pointers/counts and main gets the first grant.
    if (do_reload) begin
      fb_ptr_d  = FB_BASE;
      ov_ptr_d  = ov_base_c;
      fb_rem_d  = FB_WORDS;
      ov_rem_d  = ov_words_c;
      last_ov_d = 1'b1;
      reload_d  = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      fb_ptr_q     <= '0;
      ov_ptr_q     <= '0;
      fb_rem_q     <= '0;
      ov_rem_q     <= '0;
      mem_addr_q   <= '0;
      mem_len_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_id_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_late_q <= 1'b0;
      last_ov_q    <= 1'b1;
      reload_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fb_ptr_q     <= fb_ptr_d;
      ov_ptr_q     <= ov_ptr_d;
      fb_rem_q     <= fb_rem_d;
      ov_rem_q     <= ov_rem_d;
      mem_addr_q   <= mem_addr_d;
      mem_len_q    <= mem_len_d;
      mem_req_q    <= mem_req_d;
      mem_id_q     <= mem_id_d;
      busy_q       <= busy_d;
      frame_late_q <= frame_late_d;
      last_ov_q    <= last_ov_d;
      reload_q     <= reload_d;
    end
  end

  assign MEM_REQ    = mem_req_q;
  assign MEM_ADDR   = mem_addr_q;
  assign MEM_LEN    = mem_len_q;
  assign BUSY       = busy_q;
  assign FRAME_LATE = frame_late_q;

endmodule

// File: tb/tb_dso100fb_fetch_sched.sv
// Scoreboard bench for dso100fb_fetch_sched: expected bursts queued by stimulus,
// popped and compared by a monitor whenever a new MEM_REQ appears.
module tb_dso100fb_fetch_sched;

  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              en, frame;
  logic [ADDR_W-1:0] fb_base, ov_base;
  logic [23:0]       fb_words, ov_words;
  logic              vid_want, ov_want;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_len;
  logic              mem_id;
  logic              mem_ack, mem_done;
  logic              busy, frame_late;

  always #5 clk = ~clk;

  dso100fb_fetch_sched #(.BURST_LEN(16), .ADDR_W(ADDR_W)) dut (
    .CLK(clk), .RST(rst), .EN(en), .FRAME(frame),
    .FB_BASE(fb_base), .OV_BASE(ov_base),
    .FB_WORDS(fb_words), .OV_WORDS(ov_words),
    .VID_WANT(vid_want), .OV_WANT(ov_want),
    .MEM_REQ(mem_req), .MEM_ADDR(mem_addr), .MEM_LEN(mem_len), .MEM_ID(mem_id),
    .MEM_ACK(mem_ack), .MEM_DONE(mem_done),
    .BUSY(busy), .FRAME_LATE(frame_late)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic        id;
  } burst_t;

  burst_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int exp_fl = 0;
  int ack_delay = 0;
  int done_delay = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [7:0] l, input logic i);
    burst_t b;
    b.addr = a;
    b.len  = l;
    b.id   = i;
    exp_q.push_back(b);
  endtask

  // Memory model: ACK after ack_delay cycles of MEM_REQ, DONE done_delay cycles later.
  initial begin
    int ack_cnt;
    int done_cnt;
    logic in_flight;
    mem_ack = 1'b0;
    mem_done = 1'b0;
    ack_cnt = 0;
    done_cnt = 0;
    in_flight = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      mem_done = 1'b0;
      if (rst) begin
        ack_cnt = 0;
        done_cnt = 0;
        in_flight = 1'b0;
      end else if (mem_req && !in_flight) begin
        if (ack_cnt < ack_delay) ack_cnt++;
        else begin
          mem_ack = 1'b1;
          in_flight = 1'b1;
          ack_cnt = 0;
          done_cnt = 0;
        end
      end else if (in_flight) begin
        if (done_cnt < done_delay) done_cnt++;
        else begin
          mem_done = 1'b1;
          in_flight = 1'b0;
        end
      end
    end
  end

  // Monitor: compare each new request to the queue head; hold values until ACK.
  initial begin
    burst_t cur;
    burst_t e;
    logic in_req;
    in_req = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_req = 1'b0;
      end else begin
        if (mem_req) begin
          if (!in_req) begin
            in_req = 1'b1;
            cur.addr = mem_addr;
            cur.len  = mem_len;
            cur.id   = mem_id;
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_burst actual_addr=%h required=none", mem_addr);
            end else begin
              e = exp_q.pop_front();
              check("burst_addr", mem_addr, e.addr);
              check("burst_len", 32'(mem_len), 32'(e.len));
              check("burst_id", 32'(mem_id), 32'(e.id));
            end
          end else begin
            check("hold_addr", mem_addr, cur.addr);
            check("hold_len", 32'(mem_len), 32'(cur.len));
            check("hold_id", 32'(mem_id), 32'(cur.id));
          end
          if (mem_ack) in_req = 1'b0;
        end
        if (frame_late) begin
          checks++;
          if (exp_fl == 0) begin
            failures++;
            $display("FAIL frame_late_unexpected actual=1 required=0");
          end else begin
            exp_fl--;
          end
        end
      end
    end
  end

  task automatic pulse_frame();
    @(posedge clk);
    #1 frame = 1'b1;
    @(posedge clk);
    #1 frame = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, 32'(busy), 32'd0);
    check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_frame_late_left"}, 32'(exp_fl), 32'd0);
    exp_q.delete();
    exp_fl = 0;
  endtask

  task automatic wait_sig_ack(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!mem_ack && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_ack_seen"}, 32'(mem_ack), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    frame = 1'b0;
    fb_base = '0;
    ov_base = '0;
    fb_words = '0;
    ov_words = '0;
    vid_want = 1'b0;
    ov_want = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_len", 32'(mem_len), 32'd0);
    check("rst_mem_id", 32'(mem_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_late", 32'(frame_late), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // FRAME while disabled is ignored.
    fb_base = 32'h1000;
    fb_words = 24'd40;
    vid_want = 1'b1;
    pulse_frame();
    repeat (3) begin
      @(negedge clk);
      check("en0_frame_busy", 32'(busy), 32'd0);
    end
    en = 1'b1;

    // Main only, 40 words: 16+16+8.
    push(32'h1000, 8'd15, 1'b0);
    push(32'h1040, 8'd15, 1'b0);
    push(32'h1080, 8'd7, 1'b0);
    pulse_frame();
    wait_idle("main40");

    // Both requesters, 32 words each.
    fb_base = 32'h2000;
    fb_words = 24'd32;
    ov_base = 32'h8000;
    ov_words = 24'd32;
    ov_want = 1'b1;
`ifdef DSO100FB_OVERLAY_FETCH_EN
    push(32'h2000, 8'd15, 1'b0);
    push(32'h8000, 8'd15, 1'b1);
    push(32'h2040, 8'd15, 1'b0);
    push(32'h8040, 8'd15, 1'b1);
`else
    push(32'h2000, 8'd15, 1'b0);
    push(32'h2040, 8'd15, 1'b0);
`endif
    pulse_frame();
    wait_idle("rr");

    // Main has no words; overlay alone (only present when built in).
    fb_words = 24'd0;
    ov_base = 32'h9000;
    ov_words = 24'd64;
`ifdef DSO100FB_OVERLAY_FETCH_EN
    push(32'h9000, 8'd15, 1'b1);
    push(32'h9040, 8'd15, 1'b1);
    push(32'h9080, 8'd15, 1'b1);
    push(32'h90c0, 8'd15, 1'b1);
`endif
    pulse_frame();
    wait_idle("ov_only");
    ov_want = 1'b0;
    ov_words = 24'd0;

    // Late FRAME during WAIT: first burst completes, then restart at FB_BASE.
    fb_base = 32'h1000;
    fb_words = 24'd40;
    done_delay = 5;
    push(32'h1000, 8'd15, 1'b0);
    push(32'h1000, 8'd15, 1'b0);
    push(32'h1040, 8'd15, 1'b0);
    push(32'h1080, 8'd7, 1'b0);
    exp_fl = 1;
    pulse_frame();
    wait_sig_ack("late");
    pulse_frame();
    wait_idle("late");

    // ACK withheld 10 cycles: request must hold steady.
    done_delay = 0;
    ack_delay = 10;
    fb_base = 32'h3000;
    fb_words = 24'd16;
    push(32'h3000, 8'd15, 1'b0);
    pulse_frame();
    wait_idle("ack_hold");
    ack_delay = 0;

    // EN dropped in WAIT: no more bursts, BUSY low right after DONE.
    begin
      int n;
      done_delay = 5;
      fb_base = 32'h1000;
      fb_words = 24'd40;
      push(32'h1000, 8'd15, 1'b0);
      pulse_frame();
      wait_sig_ack("en_drop");
      @(posedge clk);
      #1 en = 1'b0;
      n = 0;
      @(negedge clk);
      while (!mem_done && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("en_drop_done_seen", 32'(mem_done), 32'd1);
      @(negedge clk);
      check("en_drop_busy", 32'(busy), 32'd0);
      repeat (5) @(negedge clk);
      wait_idle("en_drop");
      en = 1'b1;
      done_delay = 0;
    end

    // Reset in REQ abandons the burst at once.
    ack_delay = 20;
    fb_base = 32'h4000;
    fb_words = 24'd32;
    push(32'h4000, 8'd15, 1'b0);
    pulse_frame();
    repeat (3) @(negedge clk);
    check("mid_rst_req_before", 32'(mem_req), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_addr", mem_addr, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    ack_delay = 0;
    wait_idle("mid_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dso100fb_fetch_sched.md
DSO100FB_FETCH_SCHED -- requirements
Module: dso100fb_fetch_sched

Interface
REQ-001 Parameter BURST_LEN, default 16, SHALL set the maximum beats (32-bit words) per memory burst, legal range 1..256.
REQ-002 Parameter ADDR_W, default 32, SHALL set the byte address width.
REQ-003 CLK  in  1  SHALL be the single clock; all logic is synchronous to it.
REQ-004 RST  in  1  SHALL be the reset, asynchronous and active-high.
REQ-005 EN  in  1  SHALL enable fetch scheduling.
REQ-006 FRAME  in  1  SHALL be a one-cycle frame-start pulse, already in the CLK domain.
REQ-007 FB_BASE  in  ADDR_W  SHALL be the main framebuffer byte base; OV_BASE  in  ADDR_W  SHALL be the overlay byte base.
REQ-008 FB_WORDS  in  24  SHALL be the main words per frame; OV_WORDS  in  24  SHALL be the overlay words per frame.
REQ-009 VID_WANT  in  1  and OV_WANT  in  1  SHALL each mean that the requester's FIFO can accept one full burst.
REQ-010 MEM_REQ  out  1 SHALL be the burst request; MEM_ADDR  out  ADDR_W; MEM_LEN  out  8 (beats-1); MEM_ID  out  1 (0=main, 1=overlay).
REQ-011 MEM_ACK  in  1 SHALL accept the request; MEM_DONE  in  1 SHALL mark the last beat returned.
REQ-012 BUSY  out  1 SHALL be high while not in IDLE; FRAME_LATE  out  1 SHALL be a one-cycle error pulse.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, ARB, REQ, WAIT.
REQ-014 IDLE->ARB SHALL occur on FRAME while EN=1; it SHALL load the address pointers from FB_BASE/OV_BASE and the remaining counts from FB_WORDS/OV_WORDS.
REQ-015 In ARB, a requester SHALL be eligible when its WANT=1 and its remaining count is non-zero.
REQ-016 ARB SHALL grant round-robin, alternating from the last grant. After reset or a reload, main SHALL win first.
REQ-017 A grant SHALL move ARB->REQ. With no eligible requester, the FSM SHALL stay in ARB.
REQ-018 When both remaining counts are 0, ARB SHALL return to IDLE.
REQ-019 In REQ, MEM_REQ SHALL be 1, and MEM_ADDR/MEM_LEN/MEM_ID SHALL hold stable until the MEM_ACK cycle; MEM_ACK then moves REQ->WAIT.
REQ-020 MEM_LEN SHALL be min(BURST_LEN, remaining)-1.
REQ-021 On MEM_ACK, the granted pointer SHALL advance by 4*beats (modulo 2^ADDR_W wrap), and the remaining count SHALL drop by beats.
REQ-022 WAIT->ARB SHALL occur on MEM_DONE. Only one burst SHALL be outstanding at a time.
REQ-023 A FRAME in ARB/REQ/WAIT SHALL set FRAME_LATE for one cycle. Any burst in flight SHALL complete (REQ is held until ACK, then WAIT until DONE). Pointers and counts SHALL then reload and arbitration SHALL restart.
REQ-024 A FRAME coincident with MEM_DONE SHALL take the reload path of REQ-023 once.
REQ-025 EN=0 SHALL stop new grants. The in-flight burst SHALL complete, after which the FSM SHALL go to IDLE. FRAME while EN=0 SHALL be ignored.
REQ-026 FB_WORDS=0 (or OV_WORDS=0) SHALL make that requester never eligible.

Reset
REQ-027 RST=1 SHALL force IDLE, MEM_REQ=0, MEM_ADDR=0, MEM_LEN=0, MEM_ID=0, BUSY=0, FRAME_LATE=0, pointers=0, counts=0, and last grant=overlay.
REQ-028 RST asserted mid-burst SHALL abandon the burst with no completion wait.

Configuration
REQ-029 Macro DSO100FB_OVERLAY_FETCH_EN defined: the overlay requester SHALL be present as specified.
REQ-030 Macro undefined: OV_* inputs SHALL be ignored, MEM_ID SHALL be tied to 0, and ARB SHALL consider main only.

Verification
REQ-031 FB_BASE=0x1000, FB_WORDS=40, BURST_LEN=16, ACK/DONE immediate -> bursts at 0x1000/LEN 15, 0x1040/LEN 15, 0x1080/LEN 7, then IDLE.
REQ-032 Both WANT=1, FB_WORDS=OV_WORDS=32, OV_BASE=0x8000 -> MEM_ID sequence 0,1,0,1.
REQ-033 FRAME during WAIT of the first burst -> FRAME_LATE pulse; the burst completes; the next MEM_ADDR=FB_BASE.
REQ-034 MEM_ACK withheld 10 cycles -> MEM_REQ/ADDR/LEN stable all 10 cycles.
REQ-035 EN dropped in WAIT -> no further MEM_REQ after MEM_DONE; BUSY=0 next cycle.
REQ-036 Macro undefined, OV_WANT=1, OV_WORDS=64 -> MEM_ID always 0; only main bursts issued.
